bus_initiator: RTL and testbench

- Initiator side of the 386-style local bus (_ads / _ready handshake) whose target side is handled by bus_control.
- Accepts single-beat read/write requests from a local valid/ready interface.
- Runs a T1/T2 bus cycle, inserting wait states until _ready is sampled low, then returns read data or write completion.
- A timeout aborts cycles that never see _ready. Used by bridge test harnesses and any on-board logic that must master the bus.

---
 rtl/bus_pkg.sv | 18 +
 rtl/bus_initiator_if.sv | 45 ++++
 rtl/bus_wait_counter.sv | 43 ++++
 rtl/bus_initiator.sv | 150 +++++++++++++++
 tb/tb_bus_initiator.sv | 396 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the 386-style local bus (initiator and bus_control).
// Contents: bus state encoding and {m_io, d_c, w_r} cycle-type constants.
package bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_T1   = 2'd1,
        ST_T2   = 2'd2
    } bus_state_e;

    localparam logic [2:0] CYC_INTA    = 3'b000;
    localparam logic [2:0] CYC_IO_RD   = 3'b010;
    localparam logic [2:0] CYC_IO_WR   = 3'b011;
    localparam logic [2:0] CYC_CODE_RD = 3'b100;
    localparam logic [2:0] CYC_MEM_RD  = 3'b110;
    localparam logic [2:0] CYC_MEM_WR  = 3'b111;

endpackage

// File: rtl/bus_initiator_if.sv
// Request/response handshake plus local-bus pins of the bus initiator.
// master: initiator view (drives bus + response); slave: requester/target view.
interface bus_initiator_if #(
    parameter int ADDR_WIDTH = 30,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 8
);
    logic                    req_valid;
    logic                    req_ready;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic [DATA_WIDTH/8-1:0] req_be;
    logic [2:0]              req_type;
    logic [DATA_WIDTH-1:0]   req_wdata;
    logic                    rsp_valid;
    logic [DATA_WIDTH-1:0]   rsp_rdata;
    logic                    rsp_err;
    logic                    _ads;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [DATA_WIDTH/8-1:0] _be;
    logic                    m_io;
    logic                    d_c;
    logic                    w_r;
    logic [DATA_WIDTH-1:0]   dout;
    logic                    data_oe;
    logic [DATA_WIDTH-1:0]   din;
    logic                    _ready;
    logic [CNT_WIDTH-1:0]    wait_states;

    modport master (
        input  req_valid, req_addr, req_be, req_type, req_wdata,
        input  din, _ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output _ads, addr, _be, m_io, d_c, w_r, dout, data_oe,
        output wait_states
    );

    modport slave (
        output req_valid, req_addr, req_be, req_type, req_wdata,
        output din, _ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  _ads, addr, _be, m_io, d_c, w_r, dout, data_oe,
        input  wait_states
    );

endinterface

// File: rtl/bus_wait_counter.sv
// T2 wait-state counter: synchronous clear, increment, saturate at all ones.
// Ports: clk, _rst, clr_i, inc_i -> count_o, timeout_o (last T2 before abort).
module bus_wait_counter #(
    parameter int TIMEOUT   = 64,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 _rst,
    input  logic                 clr_i,
    input  logic                 inc_i,
    output logic [CNT_WIDTH-1:0] count_o,
    output logic                 timeout_o
);

    localparam bit TO_EN = (TIMEOUT != 0);
    localparam logic [CNT_WIDTH-1:0] LAST =
        TO_EN ? CNT_WIDTH'(TIMEOUT - 1) : '0;

    logic [CNT_WIDTH-1:0] count_q;
    logic [CNT_WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o   = count_q;
    // High on the T2 edge that must abort rather than count once more.
    assign timeout_o = TO_EN && (count_q == LAST);

endmodule

// File: rtl/bus_initiator.sv
// Initiator of the 386-style local bus: runs T1/T2 cycles with wait states.
// Ports: clk, _rst (async, active-low), bif (bus_initiator_if.master).
module bus_initiator
    import bus_pkg::*;
#(
    parameter int ADDR_WIDTH = 30,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 64,
    parameter int CNT_WIDTH  = 8
) (
    input  logic             clk,
    input  logic             _rst,
    bus_initiator_if.master  bif
);

    localparam int BE_W = DATA_WIDTH / 8;
    localparam logic [CNT_WIDTH-1:0] TO_WS = CNT_WIDTH'(TIMEOUT);

    bus_state_e            state_q, state_d;
    logic                  ads_q, ads_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [BE_W-1:0]       be_q, be_d;
    logic [2:0]            cyc_q, cyc_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  oe_q, oe_d;
    logic                  rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic [CNT_WIDTH-1:0]  ws_q, ws_d;

    logic                  cnt_clr;
    logic                  cnt_inc;
    logic [CNT_WIDTH-1:0]  cnt;
    logic                  cnt_to;

    bus_wait_counter #(
        .TIMEOUT   (TIMEOUT),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_cnt (
        .clk       (clk),
        ._rst      (_rst),
        .clr_i     (cnt_clr),
        .inc_i     (cnt_inc),
        .count_o   (cnt),
        .timeout_o (cnt_to)
    );

    always_comb begin
        state_d  = state_q;
        ads_d    = ads_q;
        addr_d   = addr_q;
        be_d     = be_q;
        cyc_d    = cyc_q;
        dout_d   = dout_q;
        oe_d     = oe_q;
        rvalid_d = 1'b0;
        rdata_d  = rdata_q;
        err_d    = err_q;
        ws_d     = ws_q;
        cnt_clr  = 1'b0;
        cnt_inc  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bif.req_valid) begin
                    addr_d  = bif.req_addr;
                    be_d    = ~bif.req_be;
                    cyc_d   = bif.req_type;
                    dout_d  = bif.req_wdata;
                    oe_d    = bif.req_type[0];
                    ads_d   = 1'b0;
                    cnt_clr = 1'b1;
                    state_d = ST_T1;
                end
            end
            ST_T1: begin
                ads_d   = 1'b1;
                state_d = ST_T2;
            end
            ST_T2: begin
                if (!bif._ready) begin
                    // Writes keep the previous read data visible.
                    if (!cyc_q[0]) begin
                        rdata_d = bif.din;
                    end
                    err_d    = 1'b0;
                    rvalid_d = 1'b1;
                    oe_d     = 1'b0;
                    ws_d     = cnt;
                    state_d  = ST_IDLE;
                end else if (cnt_to) begin
                    err_d    = 1'b1;
                    rvalid_d = 1'b1;
                    oe_d     = 1'b0;
                    ws_d     = TO_WS;
                    state_d  = ST_IDLE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            default: begin
                ads_d   = 1'b1;
                oe_d    = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            state_q  <= ST_IDLE;
            ads_q    <= 1'b1;
            addr_q   <= '0;
            be_q     <= '1;
            cyc_q    <= 3'b000;
            dout_q   <= '0;
            oe_q     <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            ws_q     <= '0;
        end else begin
            state_q  <= state_d;
            ads_q    <= ads_d;
            addr_q   <= addr_d;
            be_q     <= be_d;
            cyc_q    <= cyc_d;
            dout_q   <= dout_d;
            oe_q     <= oe_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            ws_q     <= ws_d;
        end
    end

    assign bif.req_ready   = (state_q == ST_IDLE);
    assign bif.rsp_valid   = rvalid_q;
    assign bif.rsp_rdata   = rdata_q;
    assign bif.rsp_err     = err_q;
    assign bif._ads        = ads_q;
    assign bif.addr        = addr_q;
    assign bif._be         = be_q;
    assign bif.m_io        = cyc_q[2];
    assign bif.d_c         = cyc_q[1];
    assign bif.w_r         = cyc_q[0];
    assign bif.dout        = dout_q;
    assign bif.data_oe     = oe_q;
    assign bif.wait_states = ws_q;

endmodule

// File: tb/tb_bus_initiator.sv
// Self-checking bench for bus_initiator: scoreboard of expected responses.
// A negedge responder plays the bus target and drives _ready.
module tb_bus_initiator;
    import bus_pkg::*;

    localparam int AW = 30;
    localparam int DW = 32;
    localparam int CW = 8;
    localparam int TO = 64;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
        logic [CW-1:0] ws;
        int            lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int accept_cyc = 0;
    int k = 0;
    int resp_ws = 0;
    logic idle_ready = 1'b1;
    logic [DW-1:0] model_rdata = '0;
    exp_t exp_q[$];

    bus_initiator_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) bif ();

    bus_initiator #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .TIMEOUT    (TO),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk  (clk),
        ._rst (rst_n),
        .bif  (bif.master)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Target model: in T2 (not idle, _ads high) hold _ready high for
    // resp_ws T2 edges, then drive it low. Elsewhere drive idle_ready.
    always @(negedge clk) begin
        if (!bif.req_ready && bif._ads) begin
            bif._ready = (k >= resp_ws) ? 1'b0 : 1'b1;
            k++;
        end else begin
            k = 0;
            bif._ready = idle_ready;
        end
    end

    task automatic send(input logic [AW-1:0] a, input logic [3:0] be,
                        input logic [2:0] t, input logic [DW-1:0] wd,
                        input logic [DW-1:0] rd, input int ws);
        exp_t e;
        bif.din = rd;
        resp_ws = ws;
        bif.req_addr = a;
        bif.req_be = be;
        bif.req_type = t;
        bif.req_wdata = wd;
        bif.req_valid = 1'b1;
        if (!t[0]) model_rdata = rd;
        e.rdata = model_rdata;
        e.err = (ws >= TO);
        e.ws = e.err ? CW'(TO) : CW'(ws);
        e.lat = e.err ? TO + 1 : ws + 2;
        exp_q.push_back(e);
    endtask

    task automatic wait_rsp(input int budget, output bit got, output int lat);
        got = 1'b0;
        lat = 0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (bif.rsp_valid) begin
                got = 1'b1;
                lat = cyc - accept_cyc;
                return;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bif._ads, bif.data_oe, bif.req_ready, bif.rsp_valid, bif.rsp_err} !== 5'b10100) begin
            errors++;
            $display("FAIL reset_ctl: got %b expected 10100",
                {bif._ads, bif.data_oe, bif.req_ready, bif.rsp_valid, bif.rsp_err});
        end
        checks++;
        if ({bif.addr, bif._be, bif.m_io, bif.d_c, bif.w_r} !== {30'h0, 4'hF, 3'b000}) begin
            errors++;
            $display("FAIL reset_bus: addr=%h be=%h cyc=%b expected 0/f/000",
                bif.addr, bif._be, {bif.m_io, bif.d_c, bif.w_r});
        end
        checks++;
        if ({bif.dout, bif.rsp_rdata, bif.wait_states} !== 72'h0) begin
            errors++;
            $display("FAIL reset_data: dout=%h rdata=%h ws=%0d expected 0",
                bif.dout, bif.rsp_rdata, bif.wait_states);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_rdata = '0;
    endtask

    task automatic test_mem_read();
        exp_t e;
        bit got;
        int lat;
        @(negedge clk);
        send(30'h0000100, 4'hF, CYC_MEM_RD, 32'h0, 32'hDEADBEEF, 0);
        @(posedge clk);
        #1;
        accept_cyc = cyc;
        checks++;
        if ({bif._ads, bif.w_r, bif._be, bif.addr} !== {1'b0, 1'b0, 4'h0, 30'h0000100}) begin
            errors++;
            $display("FAIL rd_t1: ads=%b w_r=%b be=%h addr=%h expected 0 0 0 100",
                bif._ads, bif.w_r, bif._be, bif.addr);
        end
        @(negedge clk);
        bif.req_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (bif._ads !== 1'b1) begin
            errors++;
            $display("FAIL rd_ads_width: ads=%b expected 1", bif._ads);
        end
        wait_rsp(10, got, lat);
        e = exp_q.pop_front();
        checks++;
        if (!got || lat != e.lat) begin
            errors++;
            $display("FAIL rd_latency: got=%0d lat=%0d expected %0d", got, lat, e.lat);
        end
        checks++;
        if ({bif.rsp_rdata, bif.rsp_err, bif.wait_states} !== {e.rdata, e.err, e.ws}) begin
            errors++;
            $display("FAIL rd_rsp: rdata=%h err=%b ws=%0d expected %h %b %0d",
                bif.rsp_rdata, bif.rsp_err, bif.wait_states, e.rdata, e.err, e.ws);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bif.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rd_pulse: rsp_valid=%b expected 0", bif.rsp_valid);
        end
    endtask

    task automatic test_mem_write();
        exp_t e;
        bit got;
        int lat;
        @(negedge clk);
        send(30'h0000200, 4'h3, CYC_MEM_WR, 32'h12345678, 32'h0BAD0BAD, 3);
        @(posedge clk);
        #1;
        accept_cyc = cyc;
        checks++;
        if ({bif._be, bif.data_oe, bif.w_r, bif.dout} !== {4'hC, 1'b1, 1'b1, 32'h12345678}) begin
            errors++;
            $display("FAIL wr_t1: be=%h oe=%b w_r=%b dout=%h expected c 1 1 12345678",
                bif._be, bif.data_oe, bif.w_r, bif.dout);
        end
        @(negedge clk);
        bif.req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bif.data_oe !== 1'b1 || bif.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL wr_wait: oe=%b rsp_valid=%b expected 1 0",
                bif.data_oe, bif.rsp_valid);
        end
        wait_rsp(10, got, lat);
        e = exp_q.pop_front();
        checks++;
        if (!got || lat != e.lat) begin
            errors++;
            $display("FAIL wr_latency: got=%0d lat=%0d expected %0d", got, lat, e.lat);
        end
        checks++;
        if ({bif.rsp_rdata, bif.rsp_err, bif.wait_states, bif.data_oe} !== {e.rdata, e.err, e.ws, 1'b0}) begin
            errors++;
            $display("FAIL wr_rsp: rdata=%h err=%b ws=%0d oe=%b expected %h %b %0d 0",
                bif.rsp_rdata, bif.rsp_err, bif.wait_states, bif.data_oe, e.rdata, e.err, e.ws);
        end
        checks++;
        if ({bif.addr, bif.dout} !== {30'h0000200, 32'h12345678}) begin
            errors++;
            $display("FAIL wr_hold: addr=%h dout=%h expected 200 12345678", bif.addr, bif.dout);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        bit got;
        int lat;
        @(negedge clk);
        send(30'h0000010, 4'hF, CYC_IO_RD, 32'h0, 32'hA5A50001, 0);
        @(posedge clk);
        #1;
        accept_cyc = cyc;
        checks++;
        if ({bif._ads, bif.m_io, bif.w_r} !== 3'b000) begin
            errors++;
            $display("FAIL b2b_first: ads/m_io/w_r=%b expected 000",
                {bif._ads, bif.m_io, bif.w_r});
        end
        @(negedge clk);
        send(30'h0000011, 4'h1, CYC_IO_WR, 32'hCAFEF00D, 32'hA5A50001, 0);
        wait_rsp(10, got, lat);
        e = exp_q.pop_front();
        checks++;
        if (!got || lat != e.lat || bif.rsp_rdata !== e.rdata) begin
            errors++;
            $display("FAIL b2b_rsp1: got=%0d lat=%0d rdata=%h expected lat %0d rdata %h",
                got, lat, bif.rsp_rdata, e.lat, e.rdata);
        end
        @(posedge clk);
        #1;
        accept_cyc = cyc;
        checks++;
        if ({bif.rsp_valid, bif._ads, bif.m_io, bif.w_r, bif.data_oe} !== 5'b00011) begin
            errors++;
            $display("FAIL b2b_second_ads: valid/ads/m_io/w_r/oe=%b expected 00011",
                {bif.rsp_valid, bif._ads, bif.m_io, bif.w_r, bif.data_oe});
        end
        @(negedge clk);
        bif.req_valid = 1'b0;
        wait_rsp(10, got, lat);
        e = exp_q.pop_front();
        checks++;
        if (!got || lat != e.lat || {bif.rsp_rdata, bif.rsp_err} !== {e.rdata, e.err}) begin
            errors++;
            $display("FAIL b2b_rsp2: got=%0d lat=%0d rdata=%h err=%b expected %0d %h %b",
                got, lat, bif.rsp_rdata, bif.rsp_err, e.lat, e.rdata, e.err);
        end
    endtask

    task automatic test_timeout();
        exp_t e;
        bit got;
        int lat;
        @(negedge clk);
        send(30'h0000300, 4'hF, CYC_MEM_WR, 32'h55AA55AA, 32'h0, 1000);
        @(posedge clk);
        #1;
        accept_cyc = cyc;
        @(negedge clk);
        bif.req_valid = 1'b0;
        wait_rsp(100, got, lat);
        e = exp_q.pop_front();
        checks++;
        if (!got || lat != e.lat) begin
            errors++;
            $display("FAIL to_latency: got=%0d lat=%0d expected %0d", got, lat, e.lat);
        end
        checks++;
        if ({bif.rsp_err, bif.wait_states, bif.data_oe, bif.req_ready} !== {e.err, e.ws, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL to_rsp: err=%b ws=%0d oe=%b rdy=%b expected %b %0d 0 1",
                bif.rsp_err, bif.wait_states, bif.data_oe, bif.req_ready, e.err, e.ws);
        end
        checks++;
        if (bif.rsp_rdata !== e.rdata) begin
            errors++;
            $display("FAIL to_rdata: rdata=%h expected %h", bif.rsp_rdata, e.rdata);
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        bit got;
        int lat;
        int seen;
        @(negedge clk);
        send(30'h0000400, 4'hF, CYC_MEM_WR, 32'h87654321, 32'h0, 1000);
        @(posedge clk);
        #1;
        accept_cyc = cyc;
        @(negedge clk);
        bif.req_valid = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bif._ads, bif.data_oe, bif.rsp_valid} !== 3'b100) begin
            errors++;
            $display("FAIL mid_rst_release: ads/oe/valid=%b expected 100",
                {bif._ads, bif.data_oe, bif.rsp_valid});
        end
        void'(exp_q.pop_front());
        model_rdata = '0;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (bif.rsp_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL mid_rst_rsp: rsp_valid pulses=%0d expected 0", seen);
        end
        @(negedge clk);
        send(30'h0000500, 4'hF, CYC_MEM_RD, 32'h0, 32'h13579BDF, 1);
        @(posedge clk);
        #1;
        accept_cyc = cyc;
        @(negedge clk);
        bif.req_valid = 1'b0;
        wait_rsp(10, got, lat);
        e = exp_q.pop_front();
        checks++;
        if (!got || lat != e.lat || {bif.rsp_rdata, bif.rsp_err, bif.wait_states} !== {e.rdata, e.err, e.ws}) begin
            errors++;
            $display("FAIL mid_rst_next: got=%0d lat=%0d rdata=%h err=%b ws=%0d expected %0d %h %b %0d",
                got, lat, bif.rsp_rdata, bif.rsp_err, bif.wait_states, e.lat, e.rdata, e.err, e.ws);
        end
    endtask

    task automatic test_ready_idle_t1();
        exp_t e;
        bit got;
        int lat;
        int seen;
        @(negedge clk);
        idle_ready = 1'b0;
        seen = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (bif.rsp_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL idle_ready_spurious: pulses=%0d expected 0", seen);
        end
        @(negedge clk);
        send(30'h0000600, 4'h8, CYC_CODE_RD, 32'h0, 32'h2468ACE0, 0);
        @(posedge clk);
        #1;
        accept_cyc = cyc;
        @(negedge clk);
        bif.req_valid = 1'b0;
        wait_rsp(10, got, lat);
        e = exp_q.pop_front();
        checks++;
        if (!got || lat != e.lat || {bif.rsp_rdata, bif.wait_states} !== {e.rdata, e.ws}) begin
            errors++;
            $display("FAIL t1_ready_ignored: got=%0d lat=%0d rdata=%h ws=%0d expected %0d %h %0d",
                got, lat, bif.rsp_rdata, bif.wait_states, e.lat, e.rdata, e.ws);
        end
        idle_ready = 1'b1;
    endtask

    initial begin
        bif.req_valid = 1'b0;
        bif.req_addr = '0;
        bif.req_be = '0;
        bif.req_type = 3'b000;
        bif.req_wdata = '0;
        bif.din = '0;
        bif._ready = 1'b1;
        test_reset();
        test_mem_read();
        test_mem_write();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        test_ready_idle_t1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
